// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared FSM state type and default sizing for the dump controller
package dump_pkg;

   localparam int DEF_ENTRIES = 384;
   localparam int DEF_LOG2    = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      LATCH   = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4,
      DONE    = 3'd5
   } dump_state_t;

endpackage

// File: rtl/wrap_addr_cnt.sv
// rtl/wrap_addr_cnt.sv - loadable up-counter that wraps from ENTRIES-1 back to zero
module wrap_addr_cnt #(
   parameter int ENTRIES = 384,
   parameter int W       = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] value
);

   // Wrap point is the table depth, which need not be a power of two.
   localparam logic [W-1:0] LAST = W'(ENTRIES - 1);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = (value_q == LAST) ? '0 : value_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/dump_cntrl.sv
// rtl/dump_cntrl.sv - reads one channel's sample RAM from the oldest entry and streams it to the UART
module dump_cntrl
   import dump_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int LOG2    = DEF_LOG2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dump,
   input  logic [2:0]      ch_sel,
   input  logic [LOG2-1:0] start_addr,
   input  logic [7:0]      rdata_ch1,
   input  logic [7:0]      rdata_ch2,
   input  logic [7:0]      rdata_ch3,
   input  logic [7:0]      rdata_ch4,
   input  logic [7:0]      rdata_ch5,
   input  logic            tx_done,
   output logic [LOG2-1:0] raddr,
   output logic            re,
   output logic [7:0]      tx_data,
   output logic            trmt,
   output logic            busy,
   output logic            dump_done,
   output logic            dump_err
);

   localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

   dump_state_t     state_q, state_d;
   logic [2:0]      ch_q, ch_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            re_q, re_d;
   logic            trmt_q, trmt_d;
   logic            busy_q, busy_d;
   logic            dump_done_q, dump_done_d;
   logic            dump_err_q, dump_err_d;

   logic            addr_load, addr_inc;
   logic            cnt_load, cnt_inc;
   logic [LOG2-1:0] addr_val, cnt_val, start_clean;
   logic [7:0]      rdata_sel;

   // An out-of-range oldest-sample pointer restarts the readout at entry 0.
   assign start_clean = (start_addr > LAST) ? '0 : start_addr;

   wrap_addr_cnt #(.ENTRIES(ENTRIES), .W(LOG2)) u_addr (
      .clk(clk), .rst(rst), .load(addr_load), .load_val(start_clean),
      .inc(addr_inc), .value(addr_val)
   );

   wrap_addr_cnt #(.ENTRIES(ENTRIES), .W(LOG2)) u_cnt (
      .clk(clk), .rst(rst), .load(cnt_load), .load_val('0),
      .inc(cnt_inc), .value(cnt_val)
   );

   always_comb begin
      case (ch_q)
         3'd0:    rdata_sel = rdata_ch1;
         3'd1:    rdata_sel = rdata_ch2;
         3'd2:    rdata_sel = rdata_ch3;
         3'd3:    rdata_sel = rdata_ch4;
         3'd4:    rdata_sel = rdata_ch5;
         default: rdata_sel = '0;
      endcase
   end

   // Output flops are loaded from the next state so each strobe lines up with its state.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      tx_data_d   = tx_data_q;
      busy_d      = busy_q;
      re_d        = 1'b0;
      trmt_d      = 1'b0;
      dump_done_d = 1'b0;
      dump_err_d  = 1'b0;
      addr_load   = 1'b0;
      addr_inc    = 1'b0;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump) begin
               if (ch_sel <= 3'd4) begin
                  ch_d      = ch_sel;
                  addr_load = 1'b1;
                  cnt_load  = 1'b1;
                  busy_d    = 1'b1;
                  re_d      = 1'b1;
                  state_d   = READ;
               end else begin
                  dump_err_d = 1'b1;
               end
            end
         end
         READ: state_d = LATCH;
         LATCH: begin
            tx_data_d = rdata_sel;
            trmt_d    = 1'b1;
            state_d   = SEND;
         end
         SEND: state_d = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) begin
               addr_inc = 1'b1;
               cnt_inc  = 1'b1;
               if (cnt_val == LAST) begin
                  busy_d      = 1'b0;
                  dump_done_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  re_d    = 1'b1;
                  state_d = READ;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         tx_data_q   <= '0;
         re_q        <= 1'b0;
         trmt_q      <= 1'b0;
         busy_q      <= 1'b0;
         dump_done_q <= 1'b0;
         dump_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         tx_data_q   <= tx_data_d;
         re_q        <= re_d;
         trmt_q      <= trmt_d;
         busy_q      <= busy_d;
         dump_done_q <= dump_done_d;
         dump_err_q  <= dump_err_d;
      end
   end

   assign raddr     = addr_val;
   assign re        = re_q;
   assign tx_data   = tx_data_q;
   assign trmt      = trmt_q;
   assign busy      = busy_q;
   assign dump_done = dump_done_q;
   assign dump_err  = dump_err_q;

endmodule

// File: tb/tb_dump_cntrl.sv
// tb/tb_dump_cntrl.sv - self-checking bench for dump_cntrl with RAM and UART models
module tb_dump_cntrl;

   localparam int ENTRIES = 384;
   localparam int LOG2    = 9;

   typedef struct {
      logic [2:0] ch;
      int         start;
      int         delay;
      bit         stray;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            dump = 1'b0;
   logic [2:0]      ch_sel = '0;
   logic [LOG2-1:0] start_addr = '0;
   logic [7:0]      rdata_ch1, rdata_ch2, rdata_ch3, rdata_ch4, rdata_ch5;
   logic            tx_done = 1'b0;
   logic [LOG2-1:0] raddr;
   logic            re;
   logic [7:0]      tx_data;
   logic            trmt;
   logic            busy;
   logic            dump_done;
   logic            dump_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int byte_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int prev_trmt = -1;
   int tx_delay = 0;
   bit stray_en = 1'b0;
   bit stray_toggle = 1'b0;
   int addr_q[$];
   int byte_q[$];

   dump_cntrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
      .clk(clk), .rst(rst), .dump(dump), .ch_sel(ch_sel), .start_addr(start_addr),
      .rdata_ch1(rdata_ch1), .rdata_ch2(rdata_ch2), .rdata_ch3(rdata_ch3),
      .rdata_ch4(rdata_ch4), .rdata_ch5(rdata_ch5), .tx_done(tx_done),
      .raddr(raddr), .re(re), .tx_data(tx_data), .trmt(trmt), .busy(busy),
      .dump_done(dump_done), .dump_err(dump_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int ch, input int a);
      return 8'((a & 255) + ch * 37 + ((a >> 8) & 1) * 90);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (re) begin
         rdata_ch1 <= pat(0, int'(raddr));
         rdata_ch2 <= pat(1, int'(raddr));
         rdata_ch3 <= pat(2, int'(raddr));
         rdata_ch4 <= pat(3, int'(raddr));
         rdata_ch5 <= pat(4, int'(raddr));
      end
   end

   // Scoreboard: pops expected address / byte on each read and transmit strobe.
   always @(negedge clk) begin
      if (!rst) begin
         if (re) begin
            check("re_expected", int'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) check("raddr", int'(raddr), addr_q.pop_front());
         end
         if (trmt) begin
            byte_cnt++;
            check("trmt_busy", int'(busy), 1);
            check("trmt_expected", int'(byte_q.size() > 0), 1);
            if (byte_q.size() > 0) check("tx_data", int'(tx_data), byte_q.pop_front());
            if (prev_trmt >= 0) check("trmt_gap", cyc - prev_trmt, tx_delay + 4);
            prev_trmt = cyc;
         end
         if (dump_done) begin
            done_cnt++;
            check("done_busy_low", int'(busy), 0);
         end
         if (dump_err) err_cnt++;
      end
   end

   // UART model: tx_done pulse arrives tx_delay cycles after WAIT_TX entry.
   initial forever begin
      @(negedge clk);
      if (trmt === 1'b1) begin
         @(posedge clk);
         repeat (tx_delay) @(posedge clk);
         #2 tx_done = 1'b1;
         @(posedge clk);
         #2 tx_done = 1'b0;
      end
   end

   // Disturbance: stray tx_done in READ/SEND and extra dump requests while busy.
   initial forever begin
      @(negedge clk);
      if (stray_en && (re === 1'b1 || trmt === 1'b1)) begin
         tx_done = 1'b1;
         if (re === 1'b1) begin
            dump         = 1'b1;
            ch_sel       = stray_toggle ? 3'd6 : 3'd1;
            start_addr   = LOG2'($urandom_range(0, ENTRIES - 1));
            stray_toggle = !stray_toggle;
         end
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         dump    = 1'b0;
      end
   end

   task automatic run_dump(input logic [2:0] ch, input int start, input int delay,
                           input bit stray, input int abort_at);
      int  eff, d0, e0, b0, n, bound;
      bit  valid;
      valid     = (ch <= 3'd4);
      eff       = (start >= ENTRIES) ? 0 : start;
      tx_delay  = delay;
      prev_trmt = -1;
      bound     = ENTRIES * (delay + 6) + 100;
      if (valid) begin
         for (int k = 0; k < ENTRIES; k++) begin
            addr_q.push_back((eff + k) % ENTRIES);
            byte_q.push_back(int'(pat(int'(ch), (eff + k) % ENTRIES)));
         end
      end
      d0 = done_cnt;
      e0 = err_cnt;
      b0 = byte_cnt;
      @(posedge clk);
      #1;
      dump       = 1'b1;
      ch_sel     = ch;
      start_addr = LOG2'(start);
      @(posedge clk);
      #1;
      dump     = 1'b0;
      stray_en = stray;
      @(negedge clk);
      check("busy_after_dump", int'(busy), int'(valid));
      check("err_after_dump", int'(dump_err), int'(!valid));
      if (!valid) begin
         repeat (6) @(negedge clk);
         check("err_pulse_count", err_cnt - e0, 1);
         check("busy_after_err", int'(busy), 0);
         return;
      end
      if (abort_at > 0) begin
         n = 0;
         while (byte_cnt - b0 < abort_at && n < bound) begin
            @(negedge clk);
            n++;
         end
         check("abort_point_reached", int'(byte_cnt - b0 >= abort_at), 1);
         @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         check("rst_re", int'(re), 0);
         check("rst_trmt", int'(trmt), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_tx_data", int'(tx_data), 0);
         check("rst_raddr", int'(raddr), 0);
         check("rst_dump_done", int'(dump_done), 0);
         addr_q.delete();
         byte_q.delete();
         stray_en = 1'b0;
         repeat (30) @(negedge clk);
         check("no_done_after_abort", done_cnt - d0, 0);
         check("idle_after_abort", int'(busy), 0);
         return;
      end
      n = 0;
      while (done_cnt == d0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      stray_en = 1'b0;
      repeat (4) @(negedge clk);
      check("dump_done_count", done_cnt - d0, 1);
      check("bytes_sent", byte_cnt - b0, ENTRIES);
      check("no_err_while_busy", err_cnt - e0, 0);
      check("busy_after_done", int'(busy), 0);
      check("addr_q_drained", addr_q.size(), 0);
      check("byte_q_drained", byte_q.size(), 0);
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{ch: 3'd0, start: 0,   delay: 9, stray: 1'b0};
      vecs[1] = '{ch: 3'd0, start: 383, delay: 1, stray: 1'b0};
      vecs[2] = '{ch: 3'd6, start: 0,   delay: 1, stray: 1'b0};
      vecs[3] = '{ch: 3'd1, start: 50,  delay: 2, stray: 1'b1};
      vecs[4] = '{ch: 3'd4, start: 7,   delay: 0, stray: 1'b0};
      vecs[5] = '{ch: 3'd2, start: 511, delay: 0, stray: 1'b0};
      vecs[6] = '{ch: 3'd5, start: 3,   delay: 0, stray: 1'b0};
      vecs[7] = '{ch: 3'd7, start: 3,   delay: 0, stray: 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_raddr", int'(raddr), 0);
      check("reset_re", int'(re), 0);
      check("reset_tx_data", int'(tx_data), 0);
      check("reset_trmt", int'(trmt), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_dump_done", int'(dump_done), 0);
      check("reset_dump_err", int'(dump_err), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_dump(vecs[i].ch, vecs[i].start, vecs[i].delay, vecs[i].stray, 0);
      end

      run_dump(3'd2, 10, 1, 1'b0, 100);
      run_dump(3'd2, 200, 0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
